// File: rtl/shift_rows_pipe.sv
// shift_rows_pipe: AES/Rijndael ShiftRows / InvShiftRows stage for Nb = 4, 6 or 8 columns, with the mode chosen per beat.
// Latency: 1 cycle. The shifted state is registered into a 2-entry output buffer, so inarray has no combinational path to outarray.
// Backpressure: in_ready drops while both entries are full, and outarray holds steady while out_valid && !out_ready.
// Optional: define SHIFT_ROWS_BLKCNT_EN to add the blk_count popped-beat counter and its blk_count_clr input.
module shift_rows_pipe #(
  parameter int NB = 4,
  parameter int W  = 32 * NB
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] inarray,
  input  logic         in_inv,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] outarray,
  output logic         out_valid,
  input  logic         out_ready
`ifdef SHIFT_ROWS_BLKCNT_EN
  ,
  input  logic         blk_count_clr,
  output logic [31:0]  blk_count
`endif
);

  // Rijndael row offsets: 256-bit blocks use 0,1,3,4, and the narrower blocks use 0,1,2,3.
  function automatic int row_shift(input int r);
    if (NB == 8) begin
      case (r)
        0:       return 0;
        1:       return 1;
        2:       return 3;
        default: return 4;
      endcase
    end
    return r;
  endfunction

  if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8 (got %0d)", NB);
  end

  // ------------------------------------------------------------------
  // Combinational byte permutation.
  // Byte s(r,c) lives at bit offset W-1-8*(4c+r), so byte 0 sits in the MSBs.
  // Each output byte is a fixed wire to one input byte, so this logic is only a 2:1 mux per byte.
  // ------------------------------------------------------------------
  logic [W-1:0] fwd_w;
  logic [W-1:0] inv_w;
  logic [W-1:0] shifted_w;

  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int SH = row_shift(r);
      localparam int FS = (c + SH) % NB;
      localparam int IS = (c - SH + NB) % NB;
      assign fwd_w[W-1-8*(4*c+r) -: 8] = inarray[W-1-8*(4*FS+r) -: 8];
      assign inv_w[W-1-8*(4*c+r) -: 8] = inarray[W-1-8*(4*IS+r) -: 8];
    end
  end

  assign shifted_w = in_inv ? inv_w : fwd_w;

  // ------------------------------------------------------------------
  // Two-entry output buffer.
  // Only the shifted state is stored. in_inv is consumed at capture time, so mixed-mode streams need no extra bookkeeping.
  // ------------------------------------------------------------------
  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         push_w;
  logic         pop_w;

  assign in_ready  = (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign outarray  = mem_q[rd_ptr_q];

  assign push_w = in_valid && in_ready;
  assign pop_w  = out_valid && out_ready;

  // Next-state pointers and occupancy. A push and a pop in the same cycle leave the count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_w) begin
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop_w) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push_w, pop_w})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control registers. Reset drops every buffered beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Buffer storage. Entries are cleared on reset so outarray reads zero afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else if (push_w) begin
      mem_q[wr_ptr_q] <= shifted_w;
    end
  end

`ifdef SHIFT_ROWS_BLKCNT_EN
  // ------------------------------------------------------------------
  // Count of popped beats. Clear takes priority over a same-cycle pop, and the counter wraps naturally at 2^32.
  // ------------------------------------------------------------------
  logic [31:0] blk_count_q, blk_count_d;

  // Next-state value for the popped-beat counter.
  always_comb begin
    blk_count_d = blk_count_q;
    if (blk_count_clr) begin
      blk_count_d = 32'd0;
    end else if (pop_w) begin
      blk_count_d = blk_count_q + 32'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_count_q <= 32'd0;
    end else begin
      blk_count_q <= blk_count_d;
    end
  end

  assign blk_count = blk_count_q;
`endif

endmodule
